// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// State encoding, instruction field offsets and the default halt opcode.
package instr_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    ISSUE = ST_ISSUE,
    EXEC  = ST_EXEC,
    HALT  = ST_HALT
  } state_t;

  localparam int OPC_MSB = 23;
  localparam int OP1_MSB = 19;
  localparam int OP2_MSB = 15;

  localparam logic [3:0] HALT_OP_DEF = 4'hF;

  function automatic logic [3:0] opc_of(input logic [23:0] w);
    return w[OPC_MSB -: 4];
  endfunction

endpackage

// File: rtl/instr_seq_watchdog.sv
// EXEC-phase watchdog: counts EXEC cycles without done and flags a trip.
// Only instantiated when INSTR_SEQ_WATCHDOG_EN is defined.
module instr_seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_exec,
  input  logic i_done,
  output logic o_trip
);

  logic [7:0] r_cnt;
  logic [7:0] w_inc;

  assign w_inc  = r_cnt + 8'd1;
  // Trip on the cycle whose increment would reach TIMEOUT
  assign o_trip = i_exec && !i_done && (w_inc == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_exec && !i_done) begin
      r_cnt <= w_inc;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer in front of the operand-fetch/ALU decoder.
// Optional EXEC watchdog enabled by defining INSTR_SEQ_WATCHDOG_EN.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         IW      = 24,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF,
  parameter int         TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  input  logic            imem_valid,
  output logic            dec_rst,
  output logic [3:0]      dec_opcode,
  output logic [3:0]      dec_op1,
  output logic [15:0]     dec_op2,
  input  logic            dec_done,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [15:0]     instr_count
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_imem_rd;
  logic            r_dec_rst;
  logic [3:0]      r_opc;
  logic [3:0]      r_op1;
  logic [15:0]     r_op2;
  logic            r_busy;
  logic            r_halted;
  logic            r_err;
  logic [15:0]     r_cnt;
  logic            w_trip;
  logic [3:0]      w_opc;

  assign w_opc = opc_of(imem_data[23:0]);

`ifdef INSTR_SEQ_WATCHDOG_EN
  instr_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (r_state == ISSUE),
    .i_exec  (r_state == EXEC),
    .i_done  (dec_done),
    .o_trip  (w_trip)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_trip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_imem_rd <= 1'b0;
      r_dec_rst <= 1'b1;
      r_opc     <= 4'd0;
      r_op1     <= 4'd0;
      r_op2     <= 16'd0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= FETCH;
            r_imem_rd <= 1'b1;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
          end
        end
        FETCH: begin
          if (imem_valid) begin
            r_imem_rd <= 1'b0;
            if (w_opc == HALT_OP) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_state <= ISSUE;
              r_opc   <= imem_data[OPC_MSB -: 4];
              r_op1   <= imem_data[OP1_MSB -: 4];
              r_op2   <= imem_data[OP2_MSB -: 16];
            end
          end
        end
        ISSUE: begin
          r_state   <= EXEC;
          r_dec_rst <= 1'b0;
        end
        EXEC: begin
          // Done outranks a same-cycle watchdog trip
          if (dec_done) begin
            r_state   <= FETCH;
            r_dec_rst <= 1'b1;
            r_pc      <= r_pc + 1'b1;
            r_cnt     <= r_cnt + 16'd1;
            r_imem_rd <= 1'b1;
          end else if (w_trip) begin
            r_state   <= HALT;
            r_dec_rst <= 1'b1;
            r_err     <= 1'b1;
            r_halted  <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        HALT: begin
          if (start) begin
            r_state   <= FETCH;
            r_pc      <= '0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_imem_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_imem_rd <= 1'b0;
          r_dec_rst <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_rd     = r_imem_rd;
  assign imem_addr   = r_pc;
  assign dec_rst     = r_dec_rst;
  assign dec_opcode  = r_opc;
  assign dec_op1     = r_op1;
  assign dec_op2     = r_op2;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign err         = r_err;
  assign instr_count = r_cnt;

endmodule
